// File: rtl/mcpu_alu_sequencer_pkg.sv
// mcpu_alu_sequencer_pkg: ALU command codes, sequencer states and default widths shared by the ALU, decoder and sequencer
package mcpu_alu_sequencer_pkg;
  localparam int DEF_CMD_SIZE      = 2;
  localparam int DEF_WORD_SIZE     = 8;
  localparam int DEF_REG_ADDR      = 2;
  localparam int DEF_SETTLE_CYCLES = 1;
  localparam logic [1:0] CMD_AND = 2'd0;
  localparam logic [1:0] CMD_OR  = 2'd1;
  localparam logic [1:0] CMD_XOR = 2'd2;
  localparam logic [1:0] CMD_ADD = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;
  function automatic logic alu_sets_cf(input logic [1:0] cmd);
    return cmd == CMD_ADD;
  endfunction
endpackage

// File: rtl/mcpu_alu_sequencer_if.sv
// mcpu_alu_sequencer_if: instruction handshake from decode to the ALU sequencer
//   master (decode) drives instr_valid/cmd/dst/src1/src2; slave (sequencer) drives instr_ready
interface mcpu_alu_sequencer_if
  import mcpu_alu_sequencer_pkg::*;
#(
  parameter int CMD_SIZE = DEF_CMD_SIZE,
  parameter int REG_ADDR = DEF_REG_ADDR
);
  logic                instr_valid;
  logic                instr_ready;
  logic [CMD_SIZE-1:0] instr_cmd;
  logic [REG_ADDR-1:0] instr_dst;
  logic [REG_ADDR-1:0] instr_src1;
  logic [REG_ADDR-1:0] instr_src2;
  modport master (output instr_valid, instr_cmd, instr_dst, instr_src1, instr_src2, input instr_ready);
  modport slave  (input instr_valid, instr_cmd, instr_dst, instr_src1, instr_src2, output instr_ready);
endinterface

// File: rtl/mcpu_alu_sequencer_regfile.sv
// mcpu_alu_sequencer_regfile: 2**REG_ADDR x WORD_SIZE register file
//   write ports: wb_* (writeback, higher priority) and ld_* (direct load)
//   read ports:  ra1/rd1, ra2/rd2 (operands), rd_addr/rd_data (debug), all combinational
module mcpu_alu_sequencer_regfile #(
  parameter int WORD_SIZE = 8,
  parameter int REG_ADDR  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wb_en,
  input  logic [REG_ADDR-1:0]  wb_addr,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 ld_en,
  input  logic [REG_ADDR-1:0]  ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic [REG_ADDR-1:0]  ra1,
  input  logic [REG_ADDR-1:0]  ra2,
  input  logic [REG_ADDR-1:0]  rd_addr,
  output logic [WORD_SIZE-1:0] rd1,
  output logic [WORD_SIZE-1:0] rd2,
  output logic [WORD_SIZE-1:0] rd_data
);
  localparam int N = 2**REG_ADDR;
  logic [WORD_SIZE-1:0] regs_q [N];
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      if (!reset_n) regs_q[i] <= '0;
      else if (wb_en && wb_addr == REG_ADDR'(i)) regs_q[i] <= wb_data;
      else if (ld_en && ld_addr == REG_ADDR'(i)) regs_q[i] <= ld_data;
  assign rd1     = regs_q[ra1];
  assign rd2     = regs_q[ra2];
  assign rd_data = regs_q[rd_addr];
endmodule

// File: rtl/mcpu_alu_sequencer.sv
// mcpu_alu_sequencer: multi-cycle controller that feeds the combinational ALU and writes its result back
//   clk/reset_n: clock, synchronous active-low reset; instr: instruction handshake (slave)
//   ld_*: direct register load; rd_addr/rd_data: debug read
//   alu_cmd/alu_in1/alu_in2 -> ALU, alu_out/alu_cf <- ALU; cf_flag: carry flag; done: writeback pulse
module mcpu_alu_sequencer
  import mcpu_alu_sequencer_pkg::*;
#(
  parameter int CMD_SIZE      = DEF_CMD_SIZE,
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int REG_ADDR      = DEF_REG_ADDR,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mcpu_alu_sequencer_if.slave  instr,
  input  logic                 ld_en,
  input  logic [REG_ADDR-1:0]  ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic [REG_ADDR-1:0]  rd_addr,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic [CMD_SIZE-1:0]  alu_cmd,
  output logic [WORD_SIZE-1:0] alu_in1,
  output logic [WORD_SIZE-1:0] alu_in2,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_cf,
  output logic                 cf_flag,
  output logic                 done
);
  state_t               state_q;
  logic [3:0]           cnt_q;
  logic [REG_ADDR-1:0]  dst_q;
  logic [CMD_SIZE-1:0]  cmd_q;
  logic [WORD_SIZE-1:0] in1_q, in2_q, rd1, rd2;
  logic                 ready_q, done_q, cf_q;
  mcpu_alu_sequencer_regfile #(.WORD_SIZE(WORD_SIZE), .REG_ADDR(REG_ADDR)) u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .wb_en   (state_q == ST_WB),
    .wb_addr (dst_q),
    .wb_data (alu_out),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ra1     (instr.instr_src1),
    .ra2     (instr.instr_src2),
    .rd_addr (rd_addr),
    .rd1     (rd1),
    .rd2     (rd2),
    .rd_data (rd_data)
  );
  // Operands are read combinationally at acceptance, so they are the values before any write on that edge.
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
      cmd_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (instr.instr_valid) begin
          cmd_q   <= instr.instr_cmd;
          dst_q   <= instr.instr_dst;
          in1_q   <= rd1;
          in2_q   <= rd2;
          cnt_q   <= 4'(SETTLE_CYCLES);
          ready_q <= 1'b0;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_WB;
            done_q  <= 1'b1;
          end
        end
        ST_WB: begin
          if (alu_sets_cf(cmd_q)) cf_q <= alu_cf;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  assign instr.instr_ready = ready_q;
  assign alu_cmd           = cmd_q;
  assign alu_in1           = in1_q;
  assign alu_in2           = in2_q;
  assign cf_flag           = cf_q;
  assign done              = done_q;
endmodule
